// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - per-button synchronizer, tick debounce, edge pulses, optional auto-repeat
// Auto-repeat is built only when BTN_AUTOREPEAT_EN is defined; otherwise btn_repeat is tied low.
module button_conditioner #(
    parameter int N_BTN        = 4,
    parameter int ACTIVE_LOW   = 1,
    parameter int DEBOUNCE_MS  = 10,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_1ms,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    localparam int             DW       = $clog2(DEBOUNCE_MS + 1);
    localparam logic [DW-1:0]  DB_LAST  = DW'(DEBOUNCE_MS - 1);
    localparam logic [N_BTN-1:0] RAW_IDLE = (ACTIVE_LOW != 0) ? '1 : '0;

    if (DEBOUNCE_MS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("button_conditioner: DEBOUNCE_MS, REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic [N_BTN-1:0]          sync1_q;
    logic [N_BTN-1:0]          sync2_q;
    logic [N_BTN-1:0]          s;
    logic [N_BTN-1:0][DW-1:0]  dcnt_q;
    logic [N_BTN-1:0][DW-1:0]  dcnt_d;
    logic [N_BTN-1:0]          level_q;
    logic [N_BTN-1:0]          level_d;
    logic [N_BTN-1:0]          press_q;
    logic [N_BTN-1:0]          release_q;
    logic [N_BTN-1:0]          acc_press;
    logic [N_BTN-1:0]          acc_release;

    // Released idle level in the sync flops keeps reset from looking like a press.
    assign s = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= RAW_IDLE;
            sync2_q   <= RAW_IDLE;
            dcnt_q    <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
            dcnt_q    <= dcnt_d;
            level_q   <= level_d;
            press_q   <= acc_press;
            release_q <= acc_release;
        end
    end

    always_comb begin
        level_d     = level_q;
        dcnt_d      = dcnt_q;
        acc_press   = '0;
        acc_release = '0;
        for (int i = 0; i < N_BTN; i++) begin
            if (s[i] == level_q[i]) begin
                dcnt_d[i] = '0;
            end else if (clk_1ms) begin
                if (dcnt_q[i] == DB_LAST) begin
                    level_d[i]     = s[i];
                    dcnt_d[i]      = '0;
                    acc_press[i]   = s[i];
                    acc_release[i] = ~s[i];
                end else begin
                    dcnt_d[i] = dcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BTN_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE  = 2'd0,
        RPT_DELAY = 2'd1,
        RPT_RUN   = 2'd2
    } rpt_state_e;

    localparam int            RMAX    = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int            RW      = $clog2(RMAX + 1);
    localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

    rpt_state_e               state_q [N_BTN];
    rpt_state_e               state_d [N_BTN];
    logic [N_BTN-1:0][RW-1:0] rcnt_q;
    logic [N_BTN-1:0][RW-1:0] rcnt_d;
    logic [N_BTN-1:0]         repeat_q;
    logic [N_BTN-1:0]         repeat_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= RPT_IDLE;
            end
            rcnt_q   <= '0;
            repeat_q <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= state_d[i];
            end
            rcnt_q   <= rcnt_d;
            repeat_q <= repeat_d;
        end
    end

    always_comb begin
        rcnt_d   = rcnt_q;
        repeat_d = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i] = state_q[i];
            case (state_q[i])
                RPT_IDLE: begin
                    if (acc_press[i]) begin
                        state_d[i] = RPT_DELAY;
                        rcnt_d[i]  = '0;
                    end
                end
                RPT_DELAY: begin
                    if (clk_1ms) begin
                        if (rcnt_q[i] == RD_LAST) begin
                            repeat_d[i] = 1'b1;
                            rcnt_d[i]   = '0;
                            state_d[i]  = RPT_RUN;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                end
                RPT_RUN: begin
                    if (clk_1ms) begin
                        if (rcnt_q[i] == RR_LAST) begin
                            repeat_d[i] = 1'b1;
                            rcnt_d[i]   = '0;
                        end else begin
                            rcnt_d[i] = rcnt_q[i] + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[i] = RPT_IDLE;
                    rcnt_d[i]  = '0;
                end
            endcase
            // A release landing on a repeat tick wins and suppresses that pulse.
            if (acc_release[i]) begin
                state_d[i]  = RPT_IDLE;
                rcnt_d[i]   = '0;
                repeat_d[i] = 1'b0;
            end
        end
    end

    assign btn_repeat = repeat_q;
`else
    assign btn_repeat = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench: expected pulse events queued at stimulus, matched at output
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_1ms = 1'b0;
    logic [3:0] btn_raw = 4'hF;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_repeat;

    button_conditioner dut (
        .clk         (clk),
        .reset       (reset),
        .clk_1ms     (clk_1ms),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_repeat  (btn_repeat)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          tick_no  = 0;
    int          tcnt     = 0;
    event        tick_ev;
    logic [31:0] exp_q[$];
    logic [3:0]  prev_level = 4'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t tick=%0d)", tag, obs, exp, $time, tick_no);
        end
    endtask

    // Event word: kind (1 press, 2 release, 3 repeat), button, tick stamp.
    function automatic logic [31:0] ev(input int kind, input int b, input int stamp);
        return {4'(kind), 4'(b), 24'(stamp)};
    endfunction

    task automatic push(input int kind, input int b, input int stamp);
        exp_q.push_back(ev(kind, b, stamp));
    endtask

    task automatic observe(input int kind, input int b);
        logic [31:0] o;
        o = ev(kind, b, tick_no);
        if (exp_q.size() == 0) check("unexpected", o, 32'h0);
        else                   check("event", o, exp_q.pop_front());
    endtask

    task automatic ticks(input int n);
        repeat (n) @(tick_ev);
    endtask

    // Tick generator and output monitor share one negedge process so stamps are consistent.
    always @(negedge clk) begin
        bit was_tick;
        was_tick = clk_1ms;
        if (was_tick) tick_no++;
        for (int b = 0; b < 4; b++) begin
            if (btn_press[b]) begin
                observe(1, b);
                check("press_level", {30'h0, prev_level[b], btn_level[b]}, 32'h1);
            end
            if (btn_release[b]) begin
                observe(2, b);
                check("release_level", {30'h0, prev_level[b], btn_level[b]}, 32'h2);
            end
            if (btn_repeat[b]) observe(3, b);
        end
        prev_level = btn_level;
        tcnt    = (tcnt == 9) ? 0 : tcnt + 1;
        clk_1ms = (tcnt == 0);
        if (was_tick) -> tick_ev;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at tick %0d", tick_no);
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        int e;
        reset   = 1'b0;
        btn_raw = 4'hF;
        repeat (3) @(negedge clk);
        #1 check("reset_outputs", {16'h0, btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
        @(negedge clk) reset = 1'b1;
        ticks(20);
        check("idle_level", {28'h0, btn_level}, 32'h0);

        // Clean press and release on button 0.
        btn_raw[0] = 1'b0;
        push(1, 0, tick_no + 10);
        ticks(12);
        check("level_b0", {28'h0, btn_level}, 32'h1);
        btn_raw[0] = 1'b1;
        push(2, 0, tick_no + 10);
        ticks(12);

        // Bounce on button 1: 3-tick segments never reach the debounce count.
        for (int k = 0; k < 10; k++) begin
            btn_raw[1] = (k % 2 == 0) ? 1'b0 : 1'b1;
            ticks(3);
        end
        btn_raw[1] = 1'b0;
        push(1, 1, tick_no + 10);
        ticks(12);
        check("level_b1", {28'h0, btn_level}, 32'h2);
        btn_raw[1] = 1'b1;
        push(2, 1, tick_no + 10);
        ticks(12);

        // Long hold on button 2: repeats at +300, then every 50 ticks.
        btn_raw[2] = 1'b0;
        p = tick_no + 10;
        push(1, 2, p);
`ifdef BTN_AUTOREPEAT_EN
        for (int r = 300; r <= 500; r += 50) push(3, 2, p + r);
`endif
        push(2, 2, p + 510);
        ticks(510);
        btn_raw[2] = 1'b1;
        ticks(15);
        check("level_after_hold", {28'h0, btn_level}, 32'h0);

        // Release accepted on the very tick the first repeat would fire.
        btn_raw[2] = 1'b0;
        p = tick_no + 10;
        push(1, 2, p);
        push(2, 2, p + 300);
        ticks(300);
        btn_raw[2] = 1'b1;
        ticks(15);

        // Async reset in the middle of button 3's debounce.
        btn_raw[0] = 1'b0;
        push(1, 0, tick_no + 10);
        ticks(12);
        btn_raw[3] = 1'b0;
        ticks(5);
        check("pre_reset_level", {28'h0, btn_level}, 32'h1);
        #2 reset = 1'b0;
        #1 check("async_reset", {16'h0, btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
        ticks(3);
        check("held_reset", {16'h0, btn_level, btn_press, btn_release, btn_repeat}, 32'h0);
        reset = 1'b1;
        e = tick_no + 10;
        push(1, 0, e);
        push(1, 3, e);
        ticks(12);
        check("level_after_reset", {28'h0, btn_level}, 32'h9);
        btn_raw = 4'hF;
        e = tick_no + 10;
        push(2, 0, e);
        push(2, 3, e);
        ticks(15);
        check("final_level", {28'h0, btn_level}, 32'h0);
        check("pending", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
